mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous RAM between the CPU MAR/MDR path and a DMA/loader port.
// Serialises requests into single RAM transactions, waits out the RAM read latency, and
// returns read data with a one-cycle acknowledge to the port that was served.
//
// Configuration macro:
//   MEM_ARB_RR_EN  defined   -> round-robin arbitration (port that is not `owner` wins a tie)
//                  undefined -> fixed priority (CPU always wins a tie)
//
// Ports:
//   clk, reset_n                          clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata -> cpu_ack/rdata  CPU request port
//   dma_req/we/addr/wdata -> dma_ack/rdata  DMA/loader request port
//   mem_addr/wdata/we/re, mem_rdata       RAM macro interface (read data RD_LAT cycles later)
//   busy                                  high whenever a transaction is in progress
//   owner                                 0 = CPU, 1 = DMA; port being served or last served
module mem_arbiter #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam int unsigned CntW = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e            r_state;
  state_e            w_state_d;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_owner;
  logic [CntW-1:0]   r_cnt;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dma_rdata;

  logic              w_any_req;
  logic              w_grant_dma;
  logic              w_cnt_last;

  assign w_any_req  = cpu_req | dma_req;
  assign w_cnt_last = (r_cnt == CntW'(1));

`ifdef MEM_ARB_RR_EN
  // A lone request wins outright; on a tie the port that was not served last wins.
  assign w_grant_dma = dma_req & (~cpu_req | ~r_owner);
`else
  assign w_grant_dma = dma_req & ~cpu_req;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_any_req) w_state_d = StIssue;
      StIssue: w_state_d = r_we ? StDone : StWait;
      StWait:  if (w_cnt_last) w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Request latch, latency counter and per-port read data registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_owner     <= 1'b1;
      r_cnt       <= '0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_any_req) begin
            r_we    <= w_grant_dma ? dma_we    : cpu_we;
            r_addr  <= w_grant_dma ? dma_addr  : cpu_addr;
            r_wdata <= w_grant_dma ? dma_wdata : cpu_wdata;
            r_owner <= w_grant_dma;
          end
        end
        StIssue: begin
          if (!r_we) r_cnt <= CntW'(RD_LAT);
        end
        StWait: begin
          r_cnt <= r_cnt - CntW'(1);
          // Counter at 1 marks the cycle in which the RAM presents the read data.
          if (w_cnt_last) begin
            if (r_owner) r_dma_rdata <= mem_rdata;
            else         r_cpu_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    cpu_ack = 1'b0;
    dma_ack = 1'b0;
    busy    = 1'b1;
    unique case (r_state)
      StIdle:  busy = 1'b0;
      StIssue: begin
        mem_we = r_we;
        mem_re = ~r_we;
      end
      StWait:  ;
      StDone: begin
        cpu_ack = ~r_owner;
        dma_ack = r_owner;
      end
      default: busy = 1'b0;
    endcase
  end

  // Address/data follow the latch, so they only move on the IDLE->ISSUE edge.
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign owner     = r_owner;
  assign cpu_rdata = r_cpu_rdata;
  assign dma_rdata = r_dma_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized self-checking bench for mem_arbiter (RD_LAT = 4).
// A transaction-level model decides the winner of each arbitration round from the pending
// requests and the last owner, derives the expected strobe/ack timeline from the latency rules,
// and tracks expected RAM contents and per-port read data. Honours MEM_ARB_RR_EN like the DUT.
module tb_mem_arbiter;

  localparam int unsigned AW    = 9;
  localparam int unsigned DW    = 32;
  localparam int unsigned RdLat = 4;
`ifdef MEM_ARB_RR_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0, dma_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, dma_wdata = '0;
  logic          cpu_ack, dma_ack, mem_we, mem_re, busy, owner;
  logic [DW-1:0] cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RdLat)) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_ack   (dma_ack),
    .dma_rdata (dma_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .owner     (owner)
  );

  // RAM macro: write on strobe, read data emerges RdLat cycles after the mem_re cycle.
  // Non-read slots carry junk so a mistimed capture is visible.
  logic [DW-1:0] ram [1<<AW] = '{default: '0};
  logic [DW-1:0] rd_pipe [RdLat];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    rd_pipe[0] <= mem_re ? ram[mem_addr] : $urandom;
    for (int i = 1; i < RdLat; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[RdLat-1];

  // Reference model state
  int            n_vec = 0;
  int            n_err = 0;
  bit            cpu_p = 1'b0, dma_p = 1'b0;
  logic          cpu_w, dma_w;
  logic [AW-1:0] cpu_a, dma_a;
  logic [DW-1:0] cpu_d, dma_d;
  logic [DW-1:0] ref_mem [1<<AW] = '{default: '0};
  logic [DW-1:0] cpu_rd_m = '0, dma_rd_m = '0;
  bit            owner_m = 1'b1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic new_req(input bit port);
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    w = 1'($urandom_range(0, 1));
    a = AW'($urandom_range(0, 31));
    d = $urandom;
    if (port) begin dma_p = 1'b1; dma_w = w; dma_a = a; dma_d = d; end
    else      begin cpu_p = 1'b1; cpu_w = w; cpu_a = a; cpu_d = d; end
  endtask

  task automatic drive();
    cpu_req = cpu_p; cpu_we = cpu_w; cpu_addr = cpu_a; cpu_wdata = cpu_d;
    dma_req = dma_p; dma_we = dma_w; dma_addr = dma_a; dma_wdata = dma_d;
  endtask

  // Entered and left mid-cycle while the DUT is idle. abort_at > 0 pulls reset in that cycle.
  task automatic run_round(input int abort_at);
    bit            win;
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            lat;
    drive();
    if (!cpu_p && !dma_p) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("idle_busy", 64'(busy), 64'(0));
      check_eq("idle_acks", 64'({cpu_ack, dma_ack, mem_we, mem_re}), 64'(0));
      return;
    end
    if (cpu_p && dma_p) win = RrEn ? !owner_m : 1'b0;
    else                win = dma_p;
    owner_m = win;
    w   = win ? dma_w : cpu_w;
    a   = win ? dma_a : cpu_a;
    d   = win ? dma_d : cpu_d;
    lat = w ? 2 : 2 + RdLat;
    @(posedge clk);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (c == abort_at) begin
        reset_n = 1'b0;
        #1;
        check_eq("rst_strobes", 64'({mem_we, mem_re}), 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_owner", 64'(owner), 64'(1));
        check_eq("rst_cpu_rdata", 64'(cpu_rdata), 64'(0));
        owner_m  = 1'b1;
        cpu_rd_m = '0;
        dma_rd_m = '0;
        @(negedge clk);
        check_eq("rst_no_ack", 64'({cpu_ack, dma_ack, busy}), 64'(0));
        reset_n = 1'b1;
        return;
      end
      check_eq("busy", 64'(busy), 64'(1));
      check_eq("owner", 64'(owner), 64'(win));
      check_eq("mem_we", 64'(mem_we), 64'((c == 1) && w));
      check_eq("mem_re", 64'(mem_re), 64'((c == 1) && !w));
      check_eq("mem_addr", 64'(mem_addr), 64'(a));
      if (w) check_eq("mem_wdata", 64'(mem_wdata), 64'(d));
      check_eq("cpu_ack", 64'(cpu_ack), 64'((c == lat) && !win));
      check_eq("dma_ack", 64'(dma_ack), 64'((c == lat) && win));
      if (c == lat && !w) begin
        if (win) dma_rd_m = ref_mem[a];
        else     cpu_rd_m = ref_mem[a];
      end
      check_eq("cpu_rdata", 64'(cpu_rdata), 64'(cpu_rd_m));
      check_eq("dma_rdata", 64'(dma_rdata), 64'(dma_rd_m));
      // The served port's inputs must be ignored once the request is latched.
      if (c >= 2) begin
        if (win) begin
          dma_addr = AW'($urandom); dma_wdata = $urandom; dma_we = 1'($urandom_range(0, 1));
        end else begin
          cpu_addr = AW'($urandom); cpu_wdata = $urandom; cpu_we = 1'($urandom_range(0, 1));
        end
      end
    end
    if (w) ref_mem[a] = d;
    if (win) dma_p = 1'b0;
    else     cpu_p = 1'b0;
    @(negedge clk);
    check_eq("post_busy", 64'(busy), 64'(0));
    check_eq("post_acks", 64'({cpu_ack, dma_ack}), 64'(0));
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check_eq("reset_busy", 64'(busy), 64'(0));
    check_eq("reset_owner", 64'(owner), 64'(1));
    check_eq("reset_strobes", 64'({cpu_ack, dma_ack, mem_we, mem_re}), 64'(0));
    check_eq("reset_addr", 64'(mem_addr), 64'(0));
    check_eq("reset_wdata", 64'(mem_wdata), 64'(0));
    check_eq("reset_rdata", 64'({cpu_rdata, dma_rdata}), 64'(0));
    reset_n = 1'b1;

    // CPU write then read back
    cpu_p = 1'b1; cpu_w = 1'b1; cpu_a = 9'h010; cpu_d = 32'hDEADBEEF;
    run_round(0);
    cpu_p = 1'b1; cpu_w = 1'b0;
    run_round(0);
    check_eq("cpu_readback", 64'(cpu_rdata), 64'(32'hDEADBEEF));

    // DMA preload and read at the top address
    dma_p = 1'b1; dma_w = 1'b1; dma_a = 9'h1FF; dma_d = 32'h12345678;
    run_round(0);
    dma_p = 1'b1; dma_w = 1'b0;
    run_round(0);
    check_eq("dma_readback", 64'(dma_rdata), 64'(32'h12345678));
    check_eq("dma_cpu_hold", 64'(cpu_rdata), 64'(32'hDEADBEEF));

    // Simultaneous requests, both ports keep requesting for four grants
    new_req(1'b0);
    new_req(1'b1);
    for (int i = 0; i < 4; i++) begin
      run_round(0);
      check_eq("tie_grant", 64'(owner), 64'(RrEn ? (i % 2) : 0));
      if (i < 3) new_req(owner);
    end
    run_round(0);
    check_eq("tie_after", 64'(owner), 64'(RrEn ? 0 : 1));
    while (cpu_p || dma_p) run_round(0);

    // Reset during the WAIT of a CPU read, then the held request completes
    cpu_p = 1'b1; cpu_w = 1'b0; cpu_a = 9'h010;
    run_round(3);
    run_round(0);
    check_eq("rst_reread", 64'(cpu_rdata), 64'(ref_mem[9'h010]));

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      if (!cpu_p && $urandom_range(0, 1) == 1) new_req(1'b0);
      if (!dma_p && $urandom_range(0, 1) == 1) new_req(1'b1);
      run_round(0);
    end
    while (cpu_p || dma_p) run_round(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
